// File: rtl/uart_loader.sv
// Serial boot/debug loader: turns a UART command stream (W/R/G) into word
// transactions on a valid/ready bus and answers every command on uart_tx.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        boot_done,
    output logic [31:0] boot_addr,
    output logic        err
);
    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [7:0]    ACK      = 8'h06;
    localparam logic [7:0]    NAK      = 8'h15;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_MEM, P_RESP} p_state_t;
    typedef enum logic       {TX_IDLE, TX_BIT} tx_state_t;
    typedef enum logic [1:0] {CMD_WRITE, CMD_READ, CMD_GO} cmd_t;

    assign mem_instr = 1'b0;

    // ---------------- receiver ----------------
    rx_state_t     rx_state;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_data;
    logic          rx_byte_valid, rx_frame_err;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= only; the pulse defaults below are overridden later in the block.
        rx_meta       <= uart_rx;
        rx_sync       <= rx_meta;
        rx_byte_valid <= 1'b0;
        rx_frame_err  <= 1'b0;
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_data  <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: if (!rx_sync) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_START: if (rx_cnt == BIT_HALF) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                RX_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt  <= '0;
                    rx_data <= {rx_sync, rx_data[7:1]};
                    rx_bit  <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                RX_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_IDLE;
                    if (rx_sync) rx_byte_valid <= 1'b1;
                    else         rx_frame_err  <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- command parser ----------------
    p_state_t    p_state;
    cmd_t        cmd;
    logic [1:0]  arg_cnt;
    logic [31:0] addr_next;
    logic        resp_start, tx_done;
    logic [7:0]  resp_first;
    logic [31:0] resp_rest;
    logic [1:0]  resp_count;

    assign addr_next = {rx_data, mem_addr[31:8]};

    // First response byte and the bytes queued behind it, decided in the same
    // cycle as the event so the start bit follows one cycle later.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        resp_start = 1'b0;
        resp_first = ACK;
        resp_rest  = '0;
        resp_count = '0;
        case (p_state)
            P_IDLE: if (rx_byte_valid && rx_data != 8'h57 && rx_data != 8'h52 && rx_data != 8'h47) begin
                resp_start = 1'b1;
                resp_first = NAK;
            end
            P_ADDR: resp_start = rx_byte_valid && arg_cnt == 2'd3 && cmd == CMD_GO;
            P_MEM: if (mem_ready) begin
                resp_start = 1'b1;
                if (cmd == CMD_READ) begin
                    resp_first = mem_rdata[7:0];
                    resp_rest  = {8'h00, mem_rdata[31:8]};
                    resp_count = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state   <= P_IDLE;
            cmd       <= CMD_WRITE;
            arg_cnt   <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            boot_done <= 1'b0;
            boot_addr <= '0;
            err       <= 1'b0;
        end else begin
            err <= rx_frame_err || (rx_byte_valid && (p_state == P_MEM || p_state == P_RESP));
            case (p_state)
                P_IDLE: if (rx_byte_valid) begin
                    arg_cnt <= '0;
                    case (rx_data)
                        8'h57:   begin cmd <= CMD_WRITE; p_state <= P_ADDR; end
                        8'h52:   begin cmd <= CMD_READ;  p_state <= P_ADDR; end
                        8'h47:   begin cmd <= CMD_GO;    p_state <= P_ADDR; end
                        default: p_state <= P_RESP;
                    endcase
                end
                P_ADDR: if (rx_frame_err) begin
                    p_state <= P_IDLE;
                end else if (rx_byte_valid) begin
                    mem_addr <= addr_next;
                    arg_cnt  <= arg_cnt + 1'b1;
                    if (arg_cnt == 2'd3) begin
                        case (cmd)
                            CMD_WRITE: p_state <= P_DATA;
                            CMD_READ: begin
                                mem_valid <= 1'b1;
                                mem_wstrb <= 4'h0;
                                p_state   <= P_MEM;
                            end
                            default: begin
                                boot_addr <= addr_next;
                                boot_done <= 1'b1;
                                p_state   <= P_RESP;
                            end
                        endcase
                    end
                end
                P_DATA: if (rx_frame_err) begin
                    p_state <= P_IDLE;
                end else if (rx_byte_valid) begin
                    mem_wdata <= {rx_data, mem_wdata[31:8]};
                    arg_cnt   <= arg_cnt + 1'b1;
                    if (arg_cnt == 2'd3) begin
                        mem_valid <= 1'b1;
                        mem_wstrb <= 4'hF;
                        p_state   <= P_MEM;
                    end
                end
                P_MEM: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    p_state   <= P_RESP;
                end
                P_RESP: if (tx_done) p_state <= P_IDLE;
                default: p_state <= P_IDLE;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t     tx_state;
    logic [8:0]    tx_frame;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;
    logic [31:0]   resp_data;
    logic [1:0]    resp_left;

    assign tx_done = tx_state == TX_BIT && tx_cnt == BIT_LAST && tx_bit == 4'd9 && resp_left == 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_frame  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            resp_data <= '0;
            resp_left <= '0;
            uart_tx   <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: if (resp_start) begin
                    tx_state  <= TX_BIT;
                    tx_frame  <= {1'b1, resp_first};
                    resp_data <= resp_rest;
                    resp_left <= resp_count;
                    tx_bit    <= '0;
                    tx_cnt    <= '0;
                    uart_tx   <= 1'b0;
                end
                TX_BIT: if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        // Next queued byte starts straight after the stop bit.
                        if (resp_left != 2'd0) begin
                            tx_frame  <= {1'b1, resp_data[7:0]};
                            resp_data <= {8'h00, resp_data[31:8]};
                            resp_left <= resp_left - 1'b1;
                            tx_bit    <= '0;
                            uart_tx   <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        uart_tx  <= tx_frame[0];
                        tx_frame <= {1'b1, tx_frame[8:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: a command-level model predicts bus requests
// and response bytes; independent monitors decode the bus and uart_tx.
`timescale 1ns/1ps
module tb_uart_loader;
    localparam int         CLKS = 12;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic        clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
    logic        uart_tx, mem_valid, mem_instr, boot_done, err;
    logic [31:0] mem_addr, mem_wdata, boot_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    uart_loader #(.CLKS_PER_BIT(CLKS)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .boot_done(boot_done), .boot_addr(boot_addr), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_txn_t;

    bus_txn_t    exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];
    int          errors = 0, checks = 0, exp_err = 0, err_seen = 0, stall_cfg = -1;
    logic        exp_boot_done = 1'b0;
    logic [31:0] exp_boot_addr = '0;

    // monitor state
    bus_txn_t    bus_e;
    logic [31:0] bus_a0, bus_d0;
    logic [3:0]  bus_s0;
    int          bus_wait, bus_stall;
    logic        bus_in_txn = 1'b0, bus_stable, bus_fall = 1'b0;
    logic [9:0]  tx_bits;
    logic [7:0]  tx_e;
    logic        tx_abort, err_prev = 1'b0;

    function automatic logic [31:0] default_rdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Command-level reference: what each command must do on the bus and the wire.
    task automatic model_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        case (op)
            8'h57: begin
                exp_bus.push_back('{1'b1, addr, data});
                model_mem[addr] = data;
                exp_tx.push_back(ACK);
            end
            8'h52: begin
                rd = model_mem.exists(addr) ? model_mem[addr] : default_rdata(addr);
                exp_bus.push_back('{1'b0, addr, 32'h0});
                for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
            end
            8'h47: begin
                exp_boot_done = 1'b1;
                exp_boot_addr = addr;
                exp_tx.push_back(ACK);
            end
            default: exp_tx.push_back(NAK);
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
        logic [9:0] f;
        f = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CLKS) @(posedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(exp_tx.size() == 0 && exp_bus.size() == 0, "resp_timeout", exp_tx.size(), 0);
        exp_tx.delete();
        exp_bus.delete();
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic check_boot();
        check(boot_done == exp_boot_done, "boot_done", 32'(boot_done), 32'(exp_boot_done));
        check(boot_addr == exp_boot_addr, "boot_addr", boot_addr, exp_boot_addr);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data, input bit extra);
        model_cmd(op, addr, data);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52 || op == 8'h47) send_word(addr);
        if (op == 8'h57) send_word(data);
        if (extra) begin
            exp_err++;
            send_byte(8'h55);
        end
        wait_idle();
        check_boot();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(mem_valid == 1'b0, "rst_mem_valid", 32'(mem_valid), 0);
        check(uart_tx == 1'b1, "rst_uart_tx", 32'(uart_tx), 1);
        exp_bus.delete();
        exp_tx.delete();
        exp_boot_done = 1'b0;
        exp_boot_addr = '0;
    endtask

    // Bus slave + request monitor.
    initial begin : bus_mon
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ready  = 1'b0;
                bus_in_txn = 1'b0;
                bus_fall   = 1'b0;
            end else if (bus_fall) begin
                bus_fall  = 1'b0;
                mem_ready = 1'b0;
                check(!mem_valid, "valid_fall", 32'(mem_valid), 0);
            end else if (mem_valid) begin
                if (!bus_in_txn) begin
                    bus_in_txn = 1'b1;
                    bus_wait   = 0;
                    bus_stable = 1'b1;
                    bus_a0     = mem_addr;
                    bus_d0     = mem_wdata;
                    bus_s0     = mem_wstrb;
                    bus_stall  = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
                    check(exp_bus.size() != 0, "bus_unexpected", mem_addr, 0);
                    if (exp_bus.size() != 0) begin
                        bus_e = exp_bus.pop_front();
                        check(mem_wstrb == (bus_e.we ? 4'hF : 4'h0), "bus_wstrb", 32'(mem_wstrb), bus_e.we ? 32'hF : 32'h0);
                        check(mem_addr == bus_e.addr, "bus_addr", mem_addr, bus_e.addr);
                        if (bus_e.we) check(mem_wdata == bus_e.data, "bus_wdata", mem_wdata, bus_e.data);
                    end
                end else if (mem_addr != bus_a0 || mem_wdata != bus_d0 || mem_wstrb != bus_s0) begin
                    bus_stable = 1'b0;
                end
                if (bus_wait == bus_stall) begin
                    mem_ready = 1'b1;
                    if (bus_s0 == 4'hF) begin
                        slave_mem[bus_a0] = bus_d0;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = slave_mem.exists(bus_a0) ? slave_mem[bus_a0] : default_rdata(bus_a0);
                    end
                    check(bus_stable, "bus_stable", 32'(bus_stable), 1);
                    bus_in_txn = 1'b0;
                    bus_fall   = 1'b1;
                end else begin
                    bus_wait++;
                end
            end
        end
    end

    // UART transmit decoder.
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (!rst && uart_tx == 1'b0) begin
                tx_abort = 1'b0;
                for (int i = 0; i < 10 && !tx_abort; i++) begin
                    for (int k = 0; k < ((i == 0) ? CLKS / 2 : CLKS); k++) begin
                        @(negedge clk);
                        if (rst) tx_abort = 1'b1;
                    end
                    tx_bits[i] = uart_tx;
                end
                if (!tx_abort) begin
                    check({tx_bits[9], tx_bits[0]} == 2'b10, "tx_framing", 32'({tx_bits[9], tx_bits[0]}), 32'h2);
                    check(exp_tx.size() != 0, "tx_unexpected", 32'(tx_bits[8:1]), 0);
                    if (exp_tx.size() != 0) begin
                        tx_e = exp_tx.pop_front();
                        check(tx_bits[8:1] == tx_e, "tx_byte", 32'(tx_bits[8:1]), 32'(tx_e));
                    end
                end
            end
        end
    end

    initial begin : err_mon
        forever begin
            @(negedge clk);
            if (!rst && err) begin
                err_seen++;
                check(!err_prev, "err_width", 32'(err_prev), 0);
            end
            err_prev = !rst && err;
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        int          sel;
        logic [7:0]  op;
        logic [31:0] a, n;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(uart_tx == 1'b1, "reset_uart_tx", 32'(uart_tx), 1);
        check(mem_valid == 1'b0, "reset_mem_valid", 32'(mem_valid), 0);
        check(mem_instr == 1'b0, "reset_mem_instr", 32'(mem_instr), 0);
        check(mem_wstrb == 4'h0, "reset_mem_wstrb", 32'(mem_wstrb), 0);
        check(mem_addr == 32'h0, "reset_mem_addr", mem_addr, 0);
        check(err == 1'b0, "reset_err", 32'(err), 0);
        check_boot();

        // directed write, read, go, unknown
        stall_cfg = 3;
        issue(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        stall_cfg = 0;
        model_mem[32'h1004] = 32'h1234_5678;
        slave_mem[32'h1004] = 32'h1234_5678;
        issue(8'h52, 32'h0000_1004, 32'h0, 1'b0);
        stall_cfg = -1;
        issue(8'h47, 32'h8000_0000, 32'h0, 1'b0);
        issue(8'h41, 32'h0, 32'h0, 1'b0);

        // stop bit forced low in the middle of a W
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h20);
        exp_err++;
        send_byte(8'hAA, 1'b1);
        repeat (3 * CLKS) @(negedge clk);
        check(err_seen == exp_err, "framing_err", err_seen, exp_err);
        issue(8'h57, 32'h0000_2000, 32'hCAFE_F00D, 1'b0);

        // short low glitch on the line must not produce a byte
        uart_rx = 1'b0;
        repeat (CLKS / 2 - 3) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4 * CLKS) @(negedge clk);
        check(err_seen == exp_err, "glitch_err", err_seen, exp_err);
        issue(8'h52, 32'h0000_2000, 32'h0, 1'b0);

        // byte arriving while the bus request is stalled is dropped
        stall_cfg = 300;
        issue(8'h57, 32'h0000_3000, $urandom, 1'b1);
        stall_cfg = -1;
        check(err_seen == exp_err, "drop_err", err_seen, exp_err);

        // randomized command mix
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 99);
            n   = $urandom;
            case ($urandom_range(0, 3))
                0:       a = 32'h0000_1000;
                1:       a = 32'h0000_2000;
                2:       a = 32'h0000_3000;
                default: a = n;
            endcase
            if (sel < 40)      op = 8'h57;
            else if (sel < 75) op = 8'h52;
            else if (sel < 85) op = 8'h47;
            else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52 || op == 8'h47) op = 8'($urandom);
            end
            issue(op, a, $urandom, 1'b0);
        end

        // reset while a bus request is pending
        stall_cfg = 100000;
        model_cmd(8'h52, 32'h0000_1000, 32'h0);
        send_byte(8'h52);
        send_word(32'h0000_1000);
        for (int k = 0; k < 50 && !mem_valid; k++) @(negedge clk);
        check(mem_valid == 1'b1, "valid_before_reset", 32'(mem_valid), 1);
        repeat (5) @(negedge clk);
        pulse_reset();
        stall_cfg = -1;
        check_boot();

        // reset while a read response is on the wire
        model_cmd(8'h52, 32'h0000_1004, 32'h0);
        send_byte(8'h52);
        send_word(32'h0000_1004);
        for (int k = 0; k < 200 && exp_bus.size() != 0; k++) @(negedge clk);
        repeat (CLKS * 15) @(negedge clk);
        check(exp_tx.size() != 0, "tx_before_reset", exp_tx.size(), 3);
        pulse_reset();
        issue(8'h52, 32'h0000_1004, 32'h0, 1'b0);

        repeat (4 * CLKS) @(negedge clk);
        check(err_seen == exp_err, "err_count", err_seen, exp_err);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
